// File: rtl/rr_arb_mux_4x1_pkg.sv
// Shared definitions for the round-robin 4:1 arbiter: state encoding, widths
// and the rotating-priority search used to choose a winner.
package rr_arb_mux_4x1_pkg;

  localparam int N_PORTS = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  // Return the first requesting port in the order prio, prio+1, ... (mod 4).
  // Scanning from the far end lets the nearest hit overwrite the result.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [N_PORTS-1:0] req,
                                               input logic [SEL_W-1:0]   prio);
    logic [SEL_W-1:0] idx;
    rr_pick = prio;
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      idx = prio + SEL_W'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/mux_4x1_bus.sv
// Purely combinational 4:1 bus mux, steered by the arbiter's registered select.
module mux_4x1_bus
  import rr_arb_mux_4x1_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [SEL_W-1:0] sel_i,
  input  logic [WIDTH-1:0] d0_i,
  input  logic [WIDTH-1:0] d1_i,
  input  logic [WIDTH-1:0] d2_i,
  input  logic [WIDTH-1:0] d3_i,
  output logic [WIDTH-1:0] y_o
);

  always_comb begin
    y_o = d0_i;
    case (sel_i)
      2'd0: y_o = d0_i;
      2'd1: y_o = d1_i;
      2'd2: y_o = d2_i;
      2'd3: y_o = d3_i;
      default: y_o = d0_i;
    endcase
  end

endmodule

// File: rtl/rr_arb_mux_4x1.sv
// Round-robin arbiter for four requesters sharing one valid/ready channel.
// Grants are held per packet (or per beat when LOCK_PKT=0), then priority rotates.
module rr_arb_mux_4x1
  import rr_arb_mux_4x1_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter bit LOCK_PKT = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_PORTS-1:0] req,
  input  logic [WIDTH-1:0]   in_data_0,
  input  logic [WIDTH-1:0]   in_data_1,
  input  logic [WIDTH-1:0]   in_data_2,
  input  logic [WIDTH-1:0]   in_data_3,
  input  logic [N_PORTS-1:0] in_last,
  output logic [N_PORTS-1:0] in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_last,
  input  logic               out_ready,
  output logic [N_PORTS-1:0] grant,
  output logic [SEL_W-1:0]   sel,
  output logic               busy
);

  arb_state_e         state_q;
  logic [SEL_W-1:0]   prio_q;
  logic [SEL_W-1:0]   sel_q;
  logic [N_PORTS-1:0] grant_q;
  logic               busy_q;

  logic [SEL_W-1:0]   winner;
  logic [WIDTH-1:0]   mux_data;
  logic               mux_last;
  logic               xfer;
  logic               rel;

  assign winner = rr_pick(req, prio_q);

  mux_4x1_bus #(.WIDTH(WIDTH)) u_data_mux (
    .sel_i (sel_q),
    .d0_i  (in_data_0),
    .d1_i  (in_data_1),
    .d2_i  (in_data_2),
    .d3_i  (in_data_3),
    .y_o   (mux_data)
  );

  mux_4x1_bus #(.WIDTH(1)) u_last_mux (
    .sel_i (sel_q),
    .d0_i  (in_last[0]),
    .d1_i  (in_last[1]),
    .d2_i  (in_last[2]),
    .d3_i  (in_last[3]),
    .y_o   (mux_last)
  );

  // Handshake: a beat moves when out_valid and out_ready are both high in the same
  // cycle; only the granted port sees in_ready, and it mirrors out_ready directly.
  assign out_valid = (state_q == ST_BUSY) & req[sel_q];
  assign out_data  = mux_data;
  assign out_last  = mux_last;
  assign in_ready  = ((state_q == ST_BUSY) && out_ready) ? grant_q : '0;
  assign xfer      = out_valid & out_ready;
  assign rel       = xfer & (mux_last | ~LOCK_PKT);

  assign grant = grant_q;
  assign sel   = sel_q;
  assign busy  = busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      prio_q  <= '0;
      sel_q   <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|req) begin
            sel_q   <= winner;
            grant_q <= N_PORTS'(1) << winner;
            busy_q  <= 1'b1;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // sel is left pointing at the last winner; only grant/busy drop.
          if (rel) begin
            prio_q  <= sel_q + SEL_W'(1);
            grant_q <= '0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
